// File: rtl/w_mem_addr_gen_pkg.sv
// Shared widths, FSM encoding and tile descriptor for the PE weight-memory address sequencer.
package w_mem_addr_gen_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned ROW_W  = 8;
  localparam int unsigned COL_W  = 8;
  localparam int unsigned PROD_W = ROW_W + COL_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] offset;
    logic [ROW_W-1:0]  row_num;
    logic [COL_W-1:0]  col_dim;
  } tile_cfg_t;

endpackage

// File: rtl/w_mem_addr_gen_if.sv
// Read-request channel from the address sequencer toward the weight-memory read port.
interface w_mem_addr_gen_if;
  import w_mem_addr_gen_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [ROW_W-1:0]  req_row;
  logic [COL_W-1:0]  req_col;
  logic              req_last;

  modport master (
    output req_valid, req_addr, req_row, req_col, req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_row, req_col, req_last,
    output req_ready
  );
endinterface

// File: rtl/w_mem_addr_gen_addr_comp.sv
// AddrComp: offset + row_idx*col_dim + col_idx, full-width product, result wraps modulo 2^ADDR_W.
module w_mem_addr_gen_addr_comp
  import w_mem_addr_gen_pkg::*;
(
  input  logic [ADDR_W-1:0] offset,
  input  logic [ROW_W-1:0]  row_idx,
  input  logic [COL_W-1:0]  col_dim,
  input  logic [COL_W-1:0]  col_idx,
  output logic [ADDR_W-1:0] addr_c
);

  localparam int unsigned SUM_W = ((PROD_W > ADDR_W) ? PROD_W : ADDR_W) + 1;

  logic [PROD_W-1:0] prod;

  always_comb begin
    prod   = PROD_W'(row_idx) * PROD_W'(col_dim);
    addr_c = ADDR_W'(SUM_W'(offset) + SUM_W'(prod) + SUM_W'(col_idx));
  end

endmodule

// File: rtl/w_mem_addr_gen.sv
// Weight-memory address sequencer: walks a latched tile row-major and issues one
// registered read request per element over valid/ready, then pulses done.
module w_mem_addr_gen
  import w_mem_addr_gen_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    offset,
  input  logic [ROW_W-1:0]     row_num,
  input  logic [COL_W-1:0]     col_dim,
  output logic                 busy,
  output logic                 done,
  w_mem_addr_gen_if.master     rd
);

  state_e            state_q,     state_d;
  tile_cfg_t         cfg_q,       cfg_d;
  logic              req_valid_q, req_valid_d;
  logic [ADDR_W-1:0] req_addr_q,  req_addr_d;
  logic [ROW_W-1:0]  req_row_q,   req_row_d;
  logic [COL_W-1:0]  req_col_q,   req_col_d;
  logic              req_last_q,  req_last_d;
  logic              done_q,      done_d;
  logic              busy_q,      busy_d;

  logic              fire;
  logic              col_wrap;
  logic [ROW_W-1:0]  next_row;
  logic [COL_W-1:0]  next_col;
  logic              next_last;
  logic [ADDR_W-1:0] next_addr_c;

  // Successor of the current (row, col) pair in row-major order.
  always_comb begin
    fire      = req_valid_q & rd.req_ready;
    col_wrap  = (req_col_q == (cfg_q.col_dim - COL_W'(1)));
    next_col  = col_wrap ? '0 : (req_col_q + COL_W'(1));
    next_row  = req_row_q + ROW_W'(col_wrap);
    next_last = (next_row == (cfg_q.row_num - ROW_W'(1))) &&
                (next_col == (cfg_q.col_dim - COL_W'(1)));
  end

  w_mem_addr_gen_addr_comp u_addr_comp (
    .offset  (cfg_q.offset),
    .row_idx (next_row),
    .col_dim (cfg_q.col_dim),
    .col_idx (next_col),
    .addr_c  (next_addr_c)
  );

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_row_d   = req_row_q;
    req_col_d   = req_col_q;
    req_last_d  = req_last_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cfg_d.offset  = offset;
          cfg_d.row_num = row_num;
          cfg_d.col_dim = col_dim;
          // An empty tile skips straight to the done pulse without any request.
          if ((row_num != '0) && (col_dim != '0)) begin
            state_d     = RUN;
            req_valid_d = 1'b1;
            req_addr_d  = offset;
            req_row_d   = '0;
            req_col_d   = '0;
            req_last_d  = (row_num == ROW_W'(1)) && (col_dim == COL_W'(1));
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (fire) begin
          if (req_last_q) begin
            state_d     = DONE;
            req_valid_d = 1'b0;
            req_last_d  = 1'b0;
          end else begin
            req_addr_d = next_addr_c;
            req_row_d  = next_row;
            req_col_d  = next_col;
            req_last_d = next_last;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_row_q   <= '0;
      req_col_q   <= '0;
      req_last_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_row_q   <= req_row_d;
      req_col_q   <= req_col_d;
      req_last_q  <= req_last_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign rd.req_valid = req_valid_q;
  assign rd.req_addr  = req_addr_q;
  assign rd.req_row   = req_row_q;
  assign rd.req_col   = req_col_q;
  assign rd.req_last  = req_last_q;

endmodule
